// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EX/MEM and MEM/WB registers.
// Runs one req/ack data-memory access per load/store. It stalls the upstream
// stages while the access is in flight, and it holds the MEM/WB register that
// drives register-file writeback.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   memRead_MEM         load in MEM
//   memWrite_MEM        store in MEM; a store wins when both are set
//   inputEnable_MEM     writeback value comes from inputData
//   regWrite_MEM        instruction writes the register file
//   memToReg_MEM        writeback value comes from load data
//   aluResult_MEM       address for ld/st, otherwise the writeback value
//   storeData_MEM       store data
//   dest_MEM            destination register index
//   inputData           external input port value
//   dmem_req/we/addr/wdata  registered memory request
//   dmem_ack, dmem_rdata    memory completion and read data (sampled in WAIT only)
//   stall               combinational hold for EX/MEM and earlier stages
//   regWrite_WB, dest_WB, writeData_WB  MEM/WB register
//   busError            sticky access-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES
// cycles without dmem_ack. Without it, WAIT lasts until ack and busError is 0.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead_MEM,
  input  logic                  memWrite_MEM,
  input  logic                  inputEnable_MEM,
  input  logic                  regWrite_MEM,
  input  logic                  memToReg_MEM,
  input  logic [DATA_WIDTH-1:0] aluResult_MEM,
  input  logic [DATA_WIDTH-1:0] storeData_MEM,
  input  logic [2:0]            dest_MEM,
  input  logic [DATA_WIDTH-1:0] inputData,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  stall,
  output logic                  regWrite_WB,
  output logic [2:0]            dest_WB,
  output logic [DATA_WIDTH-1:0] writeData_WB,
  output logic                  busError
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_loadBuf;
  logic                  r_regWrite_WB;
  logic [2:0]            r_dest_WB;
  logic [DATA_WIDTH-1:0] r_writeData_WB;
  logic                  w_access;
  logic                  w_start;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_wb_data;

  assign w_access = memRead_MEM | memWrite_MEM;
  assign w_start  = (r_state == S_IDLE) & w_access;
  assign w_ack    = (r_state == S_WAIT) & dmem_ack;
  assign w_stall  = w_start | (r_state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_busError;

  // Fires on the last allowed WAIT cycle. An ack in the same cycle takes priority.
  assign w_timeout = (r_state == S_WAIT) & ~dmem_ack &
                     (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter, cleared as the access is launched
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if ((r_state == S_WAIT) && !dmem_ack && !w_timeout) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busError <= 1'b0;
    end else if (w_timeout) begin
      r_busError <= 1'b1;
    end
  end

  assign busError = r_busError;
`else
  assign w_timeout = 1'b0;
  assign busError  = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_state_next = S_WAIT;
      S_WAIT:  if (w_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request fields stay frozen from launch until completion. A store wins when both flags are set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_loadBuf <= '0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= memWrite_MEM;
      r_addr  <= aluResult_MEM[ADDR_WIDTH-1:0];
      r_wdata <= storeData_MEM;
    end else if (w_ack) begin
      r_req <= 1'b0;
      if (!r_we) begin
        r_loadBuf <= dmem_rdata;
      end
    end else if (w_timeout) begin
      r_req     <= 1'b0;
      r_loadBuf <= '0;
    end
  end

  // Writeback source priority: input port, then load buffer, then ALU result
  always_comb begin
    w_wb_data = aluResult_MEM;
    if (inputEnable_MEM) begin
      w_wb_data = inputData;
    end else if (memToReg_MEM) begin
      w_wb_data = r_loadBuf;
    end
  end

  // MEM/WB register: a stall inserts a bubble and keeps the previous dest and data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regWrite_WB  <= 1'b0;
      r_dest_WB      <= '0;
      r_writeData_WB <= '0;
    end else if (w_stall) begin
      r_regWrite_WB <= 1'b0;
    end else begin
      r_regWrite_WB  <= regWrite_MEM;
      r_dest_WB      <= dest_MEM;
      r_writeData_WB <= w_wb_data;
    end
  end

  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign stall        = w_stall;
  assign regWrite_WB  = r_regWrite_WB;
  assign dest_WB      = r_dest_WB;
  assign writeData_WB = r_writeData_WB;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: bench for mem_access_stage. The bench plays both the
// upstream EX/MEM register and the data memory. The reference model is a
// per-instruction timeline: a memory op stalls for one launch cycle plus its
// WAIT cycles, then passes through one DONE cycle. Writeback appears one edge
// after the first unstalled cycle.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead_MEM, memWrite_MEM, inputEnable_MEM, regWrite_MEM, memToReg_MEM;
  logic [15:0] aluResult_MEM, storeData_MEM, inputData;
  logic [2:0]  dest_MEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, regWrite_WB, busError;
  logic [2:0]  dest_WB;
  logic [15:0] writeData_WB;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .memRead_MEM(memRead_MEM), .memWrite_MEM(memWrite_MEM),
    .inputEnable_MEM(inputEnable_MEM), .regWrite_MEM(regWrite_MEM),
    .memToReg_MEM(memToReg_MEM), .aluResult_MEM(aluResult_MEM),
    .storeData_MEM(storeData_MEM), .dest_MEM(dest_MEM), .inputData(inputData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .regWrite_WB(regWrite_WB), .dest_WB(dest_WB),
    .writeData_WB(writeData_WB), .busError(busError)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int n_stall = 0;
  int n_req   = 0;

  // Model expectations for the current cycle
  logic        exp_stall, exp_req, exp_we;
  logic [15:0] exp_addr, exp_wdata;
  logic        exp_wb_we, exp_bus;
  logic [2:0]  exp_wb_dest;
  logic [15:0] exp_wb_data;
  logic [15:0] last_load;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_wb_we   = 1'b0;
    exp_wb_dest = 3'd0;
    exp_wb_data = 16'h0;
    exp_bus     = 1'b0;
    last_load   = 16'h0;
  endtask

  // Per-cycle compare against the model
  always @(negedge clock) begin
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
        chk("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
      end
      chk("regWrite_WB", 32'(regWrite_WB), 32'(exp_wb_we));
      chk("dest_WB", 32'(dest_WB), 32'(exp_wb_dest));
      chk("writeData_WB", 32'(writeData_WB), 32'(exp_wb_data));
      chk("busError", 32'(busError), 32'(exp_bus));
      if (stall) n_stall++;
      if (dmem_req) n_req++;
    end
  end

  // Present one instruction for its whole lifetime in EX/MEM. The argument d is the number
  // of WAIT cycles before the ack cycle. When tmo is set, the memory never acks.
  task automatic run_op(input logic rd, input logic wr, input logic ie, input logic rw,
                        input logic m2r, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [2:0] dst, input int d, input bit tmo,
                        input logic [15:0] rdv, input bit fix_in, input logic [15:0] inval);
    bit mem;
    int nwait, len;
    mem   = rd | wr;
    nwait = tmo ? 15 : d + 1;
    len   = mem ? nwait + 2 : 1;
    memRead_MEM = rd; memWrite_MEM = wr; inputEnable_MEM = ie;
    regWrite_MEM = rw; memToReg_MEM = m2r; aluResult_MEM = alu;
    storeData_MEM = sd; dest_MEM = dst;
    for (int k = 0; k < len; k++) begin
      inputData  = fix_in ? inval : 16'($urandom);
      dmem_rdata = 16'($urandom);
      if (mem && k >= 1 && k <= nwait) dmem_ack = !tmo && (k == nwait);
      else dmem_ack = 1'($urandom);
      if (mem && !tmo && k == nwait) dmem_rdata = rdv;
      exp_stall = mem && (k < len - 1);
      exp_req   = mem && (k >= 1) && (k <= nwait);
      exp_we    = wr;
      exp_addr  = alu;
      exp_wdata = sd;
      @(negedge clock); #1;
      if (mem && k == nwait) begin
        if (tmo) begin
          last_load = 16'h0;
          exp_bus   = 1'b1;
        end else if (!wr) begin
          last_load = rdv;
        end
      end
      if (exp_stall) begin
        exp_wb_we = 1'b0;
      end else begin
        exp_wb_we   = rw;
        exp_wb_dest = dst;
        exp_wb_data = ie ? inputData : (m2r ? last_load : alu);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, r0;
    reset = 1'b1;
    memRead_MEM = 0; memWrite_MEM = 0; inputEnable_MEM = 0; regWrite_MEM = 0;
    memToReg_MEM = 0; aluResult_MEM = 0; storeData_MEM = 0; dest_MEM = 0;
    inputData = 0; dmem_ack = 0; dmem_rdata = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst dmem_wdata", 32'(dmem_wdata), 32'd0);
    chk("rst regWrite_WB", 32'(regWrite_WB), 32'd0);
    chk("rst dest_WB", 32'(dest_WB), 32'd0);
    chk("rst writeData_WB", 32'(writeData_WB), 32'd0);
    chk("rst busError", 32'(busError), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    reset  = 1'b0;
    chk_on = 1'b1;

    // ALU op: writeback on the next edge, no stall
    s0 = n_stall;
    run_op(0, 0, 0, 1, 0, 16'h1234, 16'h0, 3'd3, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("t1 regWrite_WB", 32'(regWrite_WB), 32'd1);
    chk("t1 dest_WB", 32'(dest_WB), 32'd3);
    chk("t1 writeData_WB", 32'(writeData_WB), 32'h1234);
    chk("t1 stalls", 32'(n_stall - s0), 32'd0);

    // Load acked in the first WAIT cycle
    s0 = n_stall; r0 = n_req;
    run_op(1, 0, 0, 1, 1, 16'h0040, 16'h0, 3'd5, 0, 1'b0, 16'hBEEF, 1'b0, 16'h0);
    chk("t2 stalls", 32'(n_stall - s0), 32'd2);
    chk("t2 req cycles", 32'(n_req - r0), 32'd1);
    chk("t2 regWrite_WB", 32'(regWrite_WB), 32'd1);
    chk("t2 writeData_WB", 32'(writeData_WB), 32'hBEEF);

    // Store acked in the fourth WAIT cycle
    s0 = n_stall; r0 = n_req;
    run_op(0, 1, 0, 0, 0, 16'h0010, 16'h00AA, 3'd1, 3, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("t3 stalls", 32'(n_stall - s0), 32'd5);
    chk("t3 req cycles", 32'(n_req - r0), 32'd4);
    chk("t3 regWrite_WB", 32'(regWrite_WB), 32'd0);

    // The input port takes priority over the load buffer
    run_op(0, 0, 1, 1, 1, 16'h5555, 16'h0, 3'd6, 0, 1'b0, 16'h0, 1'b1, 16'h0007);
    chk("t4 writeData_WB", 32'(writeData_WB), 32'h0007);

`ifdef MEM_TIMEOUT_EN
    // Load that is never acked
    s0 = n_stall; r0 = n_req;
    run_op(1, 0, 0, 1, 1, 16'h0080, 16'h0, 3'd2, 0, 1'b1, 16'h0, 1'b0, 16'h0);
    chk("t5 req cycles", 32'(n_req - r0), 32'd15);
    chk("t5 busError", 32'(busError), 32'd1);
    chk("t5 writeData_WB", 32'(writeData_WB), 32'h0000);
    run_op(0, 0, 0, 1, 0, 16'h0099, 16'h0, 3'd4, 0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("t5 busError sticky", 32'(busError), 32'd1);
`endif

    // Reset while in WAIT abandons the access
    chk_on = 1'b0;
    memRead_MEM = 1; memWrite_MEM = 0; regWrite_MEM = 1; memToReg_MEM = 1;
    aluResult_MEM = 16'h0100; dmem_ack = 0;
    @(posedge clock); #1;
    chk("t6 req in WAIT", 32'(dmem_req), 32'd1);
    chk("t6 stall in WAIT", 32'(stall), 32'd1);
    reset = 1'b1; memRead_MEM = 0; regWrite_MEM = 0;
    @(posedge clock); #1;
    chk("t6 dmem_req", 32'(dmem_req), 32'd0);
    chk("t6 stall", 32'(stall), 32'd0);
    chk("t6 regWrite_WB", 32'(regWrite_WB), 32'd0);
    chk("t6 busError", 32'(busError), 32'd0);
    reset = 1'b0;
    model_reset();
    chk_on = 1'b1;
    run_op(1, 0, 0, 1, 1, 16'h0200, 16'h0, 3'd7, 1, 1'b0, 16'hCAFE, 1'b0, 16'h0);
    chk("t6 post-reset load", 32'(writeData_WB), 32'hCAFE);

    // Random mix of ALU ops, loads, stores, and combined read+write
    for (int i = 0; i < 80; i++) begin
      automatic int kind = $urandom_range(0, 9);
      automatic logic rd = (kind >= 4 && kind <= 6) || kind == 9;
      automatic logic wr = kind >= 7;
      run_op(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
             16'($urandom), 3'($urandom), $urandom_range(0, 4), 1'b0,
             16'($urandom), 1'b0, 16'h0);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
